// File: rtl/pia_arb_pkg.sv
// Shared types and constants for the PIA access arbiter.
// Optional feature macro: PIA_ARB_ROUNDROBIN_EN (see pia_arb_pick).
package pia_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  localparam logic [1:0] REG_PA   = 2'd0;
  localparam logic [1:0] REG_PB   = 2'd1;
  localparam logic [1:0] REG_PC   = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

endpackage

// File: rtl/pia_arb_pick.sv
// Two-way grant selection between CPU and host requests.
// PIA_ARB_ROUNDROBIN_EN selects round-robin; otherwise CPU wins ties.
module pia_arb_pick
  import pia_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic host_req,
  input  logic prio,
  output logic grant_valid,
  output logic grant
);

  assign grant_valid = cpu_req | host_req;

`ifdef PIA_ARB_ROUNDROBIN_EN
  // prio names the port favoured on a tie
  always_comb begin
    grant = PORT_CPU;
    if (cpu_req && host_req) begin
      grant = prio;
    end else if (host_req) begin
      grant = PORT_HOST;
    end
  end
`else
  logic unused_prio;
  assign unused_prio = prio;
  assign grant = cpu_req ? PORT_CPU : PORT_HOST;
`endif

endmodule

// File: rtl/pia_access_arbiter.sv
// CPU/host arbiter sequencing setup/strobe/recover cycles to the 8255 PIA.
// Tie-break policy set by PIA_ARB_ROUNDROBIN_EN inside pia_arb_pick.
module pia_access_arbiter
  import pia_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [1:0] host_addr,
  input  logic [7:0] host_din,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       pia_cs,
  output logic [1:0] pia_address,
  output logic [7:0] pia_din,
  output logic       pia_we,
  input  logic [7:0] pia_dout
);

  state_t state;
  logic   lat_we;
  logic   lat_port;
  logic   prio;
  logic   grant_valid;
  logic   grant;

  pia_arb_pick u_pick (
    .cpu_req     (cpu_req),
    .host_req    (host_req),
    .prio        (prio),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_port    <= PORT_CPU;
      prio        <= PORT_CPU;
      pia_cs      <= 1'b0;
      pia_we      <= 1'b0;
      pia_address <= 2'd0;
      pia_din     <= 8'd0;
      cpu_ack     <= 1'b0;
      host_ack    <= 1'b0;
      cpu_rdata   <= 8'd0;
      host_rdata  <= 8'd0;
    end else begin
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      pia_we   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            state    <= SETUP;
            pia_cs   <= 1'b1;
            lat_port <= grant;
            prio     <= ~grant;
            if (grant == PORT_HOST) begin
              lat_we      <= host_we;
              pia_address <= host_addr;
              pia_din     <= host_din;
            end else begin
              lat_we      <= cpu_we;
              pia_address <= cpu_addr;
              pia_din     <= cpu_din;
            end
          end
        end
        SETUP: begin
          state  <= STROBE;
          pia_we <= lat_we;
        end
        STROBE: begin
          state <= RECOVER;
          // pia_dout is combinational; sample it at the end of the strobe
          if (!lat_we) begin
            if (lat_port == PORT_HOST) begin
              host_rdata <= pia_dout;
            end else begin
              cpu_rdata <= pia_dout;
            end
          end
          if (lat_port == PORT_HOST) begin
            host_ack <= 1'b1;
          end else begin
            cpu_ack <= 1'b1;
          end
        end
        RECOVER: begin
          state  <= IDLE;
          pia_cs <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pia_access_arbiter.sv
// Self-checking bench for pia_access_arbiter: directed table,
// hand-written corner sequences and a random run against a model.
module tb_pia_access_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, host_req, host_we;
  logic [1:0] cpu_addr, host_addr;
  logic [7:0] cpu_din, host_din;
  logic       cpu_ack, host_ack;
  logic [7:0] cpu_rdata, host_rdata;
  logic       pia_cs, pia_we;
  logic [1:0] pia_address;
  logic [7:0] pia_din, pia_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pia_access_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_din     (cpu_din),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_din    (host_din),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .pia_cs      (pia_cs),
    .pia_address (pia_address),
    .pia_din     (pia_din),
    .pia_we      (pia_we),
    .pia_dout    (pia_dout)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  int       m_cnt;
  bit       m_who;
  bit       m_we;
  bit       m_prio;
  bit [1:0] m_addr;
  bit [7:0] m_din;
  bit [7:0] m_rd [2];

  function automatic bit pick_model(bit c, bit h, bit favor);
`ifdef PIA_ARB_ROUNDROBIN_EN
    if (c && h) return favor;
`else
    if (c && h) return 1'b0;
`endif
    return c ? 1'b0 : 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt   <= 0;
      m_who   <= 1'b0;
      m_we    <= 1'b0;
      m_prio  <= 1'b0;
      m_addr  <= 2'd0;
      m_din   <= 8'd0;
      m_rd[0] <= 8'd0;
      m_rd[1] <= 8'd0;
    end else if (m_cnt == 0) begin
      if (cpu_req || host_req) begin
        if (pick_model(cpu_req, host_req, m_prio)) begin
          m_who  <= 1'b1;
          m_we   <= host_we;
          m_addr <= host_addr;
          m_din  <= host_din;
          m_prio <= 1'b0;
        end else begin
          m_who  <= 1'b0;
          m_we   <= cpu_we;
          m_addr <= cpu_addr;
          m_din  <= cpu_din;
          m_prio <= 1'b1;
        end
        m_cnt <= 1;
      end
    end else begin
      if (m_cnt == 2 && !m_we) m_rd[m_who] <= pia_dout;
      m_cnt <= (m_cnt == 3) ? 0 : m_cnt + 1;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    bit       host;
    bit       we;
    bit [1:0] addr;
    bit [7:0] din;
    bit [7:0] dout;
    bit [3:0] exp_we;
    bit [7:0] exp_cpu_rd;
    bit [7:0] exp_host_rd;
  } vec_t;

  vec_t vecs [5];

  task automatic drive_port(input bit host, input bit req, input bit we,
                            input bit [1:0] addr, input bit [7:0] din);
    if (host) begin
      host_req = req; host_we = we; host_addr = addr; host_din = din;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_din = din;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit [3:0] cs_p, we_p, own_p, oth_p;
    bit [1:0] a_s;
    bit [7:0] d_s;
    cs_p = 0; we_p = 0; own_p = 0; oth_p = 0; a_s = 0; d_s = 0;
    pia_dout = v.dout;
    drive_port(v.host, 1'b1, v.we, v.addr, v.din);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cs_p[k]  = pia_cs;
      we_p[k]  = pia_we;
      own_p[k] = v.host ? host_ack : cpu_ack;
      oth_p[k] = v.host ? cpu_ack : host_ack;
      if (k == 1) begin
        a_s = pia_address;
        d_s = pia_din;
      end
      if (k == 2) drive_port(v.host, 1'b0, 1'b0, 2'd0, 8'd0);
    end
    chk({tag, "_cs"}, {28'd0, cs_p}, 32'h7);
    chk({tag, "_we"}, {28'd0, we_p}, {28'd0, v.exp_we});
    chk({tag, "_ack"}, {28'd0, own_p}, 32'h4);
    chk({tag, "_oack"}, {28'd0, oth_p}, 32'h0);
    chk({tag, "_addr"}, {30'd0, a_s}, {30'd0, v.addr});
    chk({tag, "_din"}, {24'd0, d_s}, {24'd0, v.din});
    chk({tag, "_crd"}, {24'd0, cpu_rdata}, {24'd0, v.exp_cpu_rd});
    chk({tag, "_hrd"}, {24'd0, host_rdata}, {24'd0, v.exp_host_rd});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit       got, first_cpu, first_host, sec_cpu, sec_host;
    int       acks, ack2_at;
    vec_t     fresh;

    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_din = 0;
    pia_dout = 8'h00;

    vecs[0] = '{0, 1, 2'd0, 8'hA5, 8'h99, 4'b0010, 8'h00, 8'h00};
    vecs[1] = '{1, 0, 2'd1, 8'h00, 8'h3C, 4'b0000, 8'h00, 8'h3C};
    vecs[2] = '{1, 1, 2'd3, 8'h05, 8'hEE, 4'b0010, 8'h00, 8'h3C};
    vecs[3] = '{0, 0, 2'd2, 8'h11, 8'h5A, 4'b0000, 8'h5A, 8'h3C};
    vecs[4] = '{0, 1, 2'd3, 8'hFF, 8'h77, 4'b0010, 8'h5A, 8'h3C};

    @(negedge clk);
    @(negedge clk);
    chk("rst_cs", {31'd0, pia_cs}, 32'd0);
    chk("rst_we", {31'd0, pia_we}, 32'd0);
    chk("rst_addr", {30'd0, pia_address}, 32'd0);
    chk("rst_din", {24'd0, pia_din}, 32'd0);
    chk("rst_acks", {30'd0, cpu_ack, host_ack}, 32'd0);
    chk("rst_rd", {16'd0, cpu_rdata, host_rdata}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // simultaneous requests, CPU re-requesting after its first ack
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 2'd1; cpu_din = 8'h11;
    host_req = 1; host_we = 1; host_addr = 2'd2; host_din = 8'h22;
    got = 0; first_cpu = 0; first_host = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (cpu_ack || host_ack) begin
        got = 1; first_cpu = cpu_ack; first_host = host_ack;
      end
    end
    chk("tie1_seen", {31'd0, got}, 32'd1);
    chk("tie1_grant", {30'd0, first_cpu, first_host}, 32'h2);
    got = 0; sec_cpu = 0; sec_host = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (cpu_ack || host_ack) begin
        got = 1; sec_cpu = cpu_ack; sec_host = host_ack;
      end
    end
    cpu_req = 0;
    host_req = 0;
    chk("tie2_seen", {31'd0, got}, 32'd1);
`ifdef PIA_ARB_ROUNDROBIN_EN
    chk("tie2_grant", {30'd0, sec_cpu, sec_host}, 32'h1);
`else
    chk("tie2_grant", {30'd0, sec_cpu, sec_host}, 32'h2);
`endif
    @(negedge clk);
    @(negedge clk);

    // request held after ack: back-to-back transactions every 4 cycles
    do_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 2'd2; cpu_din = 8'h00;
    pia_dout = 8'h6B;
    acks = 0; ack2_at = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        acks++;
        if (acks == 2) begin
          ack2_at = k;
          cpu_req = 0;
        end
      end
    end
    chk("b2b_acks", acks, 32'd2);
    chk("b2b_pos", ack2_at, 32'd6);
    chk("b2b_rd", {24'd0, cpu_rdata}, 32'h6B);

    // reset during the strobe of a write
    cpu_req = 1; cpu_we = 1; cpu_addr = 2'd2; cpu_din = 8'h77;
    @(negedge clk);
    @(negedge clk);
    chk("mid_we_pre", {31'd0, pia_we}, 32'd1);
    reset = 1'b1;
    cpu_req = 0;
    #1;
    chk("mid_cs", {31'd0, pia_cs}, 32'd0);
    chk("mid_we", {31'd0, pia_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (cpu_ack || host_ack || pia_cs) acks++;
    end
    chk("mid_noack", acks, 32'd0);
    fresh = '{0, 1, 2'd2, 8'h77, 8'h00, 4'b0010, 8'h00, 8'h00};
    run_vec(fresh, "fresh");

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      chk("r_cs", {31'd0, pia_cs}, {31'd0, m_cnt != 0});
      chk("r_we", {31'd0, pia_we}, {31'd0, m_cnt == 2 && m_we});
      chk("r_addr", {30'd0, pia_address}, {30'd0, m_addr});
      chk("r_din", {24'd0, pia_din}, {24'd0, m_din});
      chk("r_cack", {31'd0, cpu_ack}, {31'd0, m_cnt == 3 && !m_who});
      chk("r_hack", {31'd0, host_ack}, {31'd0, m_cnt == 3 && m_who});
      chk("r_crd", {24'd0, cpu_rdata}, {24'd0, m_rd[0]});
      chk("r_hrd", {24'd0, host_rdata}, {24'd0, m_rd[1]});
      pia_dout = 8'($urandom);
      if (cpu_req) begin
        if (m_cnt == 3 && !m_who) begin
          if ($urandom_range(3) == 0)
            drive_port(0, 1, 1'($urandom), 2'($urandom), 8'($urandom));
          else
            cpu_req = 0;
        end
      end else if ($urandom_range(2) == 0) begin
        drive_port(0, 1, 1'($urandom), 2'($urandom), 8'($urandom));
      end
      if (host_req) begin
        if (m_cnt == 3 && m_who) begin
          if ($urandom_range(3) == 0)
            drive_port(1, 1, 1'($urandom), 2'($urandom), 8'($urandom));
          else
            host_req = 0;
        end
      end else if ($urandom_range(2) == 0) begin
        drive_port(1, 1, 1'($urandom), 2'($urandom), 8'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
